// File: rtl/receptor_pkg.sv
// Shared types and constants for the serial receiver.
package receptor_pkg;

  typedef enum logic [1:0] {IDLE, DATA, STOP, HOLD} rx_state_t;

  // Level the line rests at between frames; also the valid stop-bit level.
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/contador_bits.sv
// Data-bit counter for the serial receiver.
// It advances only when enabled. It is cleared explicitly at the start of each frame.
// It raises a terminal flag on the last data bit.
module contador_bits #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  // Counter register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/receptor_serial.sv
// Serial-line receiver.
// A frame is a start bit (0), then WIDTH data bits sent LSB-first, then a stop bit (1).
// The line is sampled only on bit-strobe cycles.
// A finished word is handed to the consumer with a valid/ready handshake.
// Every output is registered.
module receptor_serial
  import receptor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  rx_state_t        state, state_nx;
  logic [WIDTH-1:0] shift_reg, shift_nx, data_nx;
  logic             valid_nx, busy_nx, frame_err_nx, overrun_nx;
  logic             cnt_clear, cnt_en, cnt_last;
  logic [CW-1:0]    cnt;
  logic             start_bit;

  assign start_bit = enable && (din != IDLE_LEVEL);

  contador_bits #(.WIDTH(WIDTH), .CW(CW)) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  // State, shift register and output registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_reg <= shift_nx;
      data_out  <= data_nx;
      valid     <= valid_nx;
      busy      <= busy_nx;
      frame_err <= frame_err_nx;
      overrun   <= overrun_nx;
    end
  end

  // Next-state and next-output logic; the error flags default low so they pulse for one cycle.
  always_comb begin
    state_nx     = state;
    shift_nx     = shift_reg;
    data_nx      = data_out;
    valid_nx     = valid;
    frame_err_nx = 1'b0;
    overrun_nx   = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      IDLE: begin
        if (start_bit) begin
          state_nx  = DATA;
          cnt_clear = 1'b1;
        end
      end
      DATA: begin
        if (enable) begin
          shift_nx[cnt] = din;
          if (cnt_last) state_nx = STOP;
          else          cnt_en   = 1'b1;
        end
      end
      STOP: begin
        if (enable) begin
          if (din == IDLE_LEVEL) begin
            state_nx = HOLD;
            data_nx  = shift_reg;
            valid_nx = 1'b1;
          end else begin
            state_nx     = IDLE;
            frame_err_nx = 1'b1;
          end
        end
      end
      HOLD: begin
        if (valid && ready) begin
          valid_nx = 1'b0;
          if (start_bit) begin
            state_nx  = DATA;
            cnt_clear = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (start_bit) begin
          overrun_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == DATA) || (state_nx == STOP);
  end

endmodule
